// File: rtl/uart_rx_ctrl_pkg.sv
// rtl/uart_rx_ctrl_pkg.sv - shared UART controller types and defaults
//
// Holds the packet-checker state encodings, the error cause codes and the
// default packet framing shared by the TX and RX controllers.
package uart_rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2,
        ST_ERR     = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISMATCH = 2'd1,
        ERR_FRAME    = 2'd2,
        ERR_TIMEOUT  = 2'd3
    } err_code_t;

    localparam logic [7:0] DEF_START_CHAR = 8'h41;
    localparam int         DEF_PKT_LEN    = 6;

    // Successor byte in the packet pattern; wraps FF -> 00.
    function automatic logic [7:0] next_byte(input logic [7:0] b);
        return b + 8'd1;
    endfunction

endpackage

// File: rtl/uart_gap_timer.sv
// rtl/uart_gap_timer.sv - inter-byte gap timer with expiry pulse
//
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   clr     - clear the count (priority over en)
//   en      - count this cycle
//   expired - high in the cycle the count sits at TIMEOUT_CYC-1 while en=1
module uart_gap_timer #(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int             W    = $clog2(TIMEOUT_CYC);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = en && (cnt == LAST);

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive packet checker with good/bad statistics
//
// Checks packets of START_CHAR followed by PKT_LEN-1 incrementing bytes.
// Ports:
//   clk, rst      - clock, synchronous active-high reset
//   rx_valid      - one-cycle strobe qualifying rx_data / rx_frame_err
//   rx_data       - received byte
//   rx_frame_err  - stop-bit error for the byte
//   clr_stats     - clear good_cnt, bad_cnt, err_code
//   pkt_done      - pulse at the end of each packet attempt
//   pkt_ok        - with pkt_done: 1 good, 0 bad
//   err_code      - cause of the last bad packet
//   good_cnt      - saturating good packet count
//   bad_cnt       - saturating bad packet count
//   busy          - packet collection in progress
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter logic [7:0] START_CHAR  = DEF_START_CHAR,
    parameter int         PKT_LEN     = DEF_PKT_LEN,
    parameter int         TIMEOUT_CYC = 50000,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    input  logic             rx_frame_err,
    input  logic             clr_stats,
    output logic             pkt_done,
    output logic             pkt_ok,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic             busy
);

    localparam logic [7:0]       LEN8    = 8'(PKT_LEN);
    localparam logic [CNT_W-1:0] CNT_INC = CNT_W'(1);

    rx_state_t  state, state_nxt;
    logic [7:0] exp_byte, exp_nxt;
    logic [7:0] idx, idx_nxt;
    err_code_t  err_pend, pend_nxt;
    err_code_t  err_q;

    logic is_start;
    logic timer_clr;
    logic timer_en;
    logic expired;

    assign is_start  = rx_valid && !rx_frame_err && (rx_data == START_CHAR);

    // Timer only runs while collecting and restarts on every byte; outside
    // COLLECT it is held at zero so entry into COLLECT starts from a clean count.
    assign timer_clr = (state != ST_COLLECT) || rx_valid;
    assign timer_en  = (state == ST_COLLECT) && !rx_valid;

    uart_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        exp_nxt   = exp_byte;
        idx_nxt   = idx;
        pend_nxt  = err_pend;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                // DONE/ERR also hunt so a start byte right after a packet is kept.
                if (is_start) begin
                    state_nxt = ST_COLLECT;
                    exp_nxt   = next_byte(START_CHAR);
                    idx_nxt   = 8'd1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (rx_valid) begin
                    if (rx_frame_err) begin
                        state_nxt = ST_ERR;
                        pend_nxt  = ERR_FRAME;
                    end else if (rx_data != exp_byte) begin
                        state_nxt = ST_ERR;
                        pend_nxt  = ERR_MISMATCH;
                    end else begin
                        idx_nxt = idx + 8'd1;
                        exp_nxt = next_byte(exp_byte);
                        if (idx_nxt == LEN8) begin
                            state_nxt = ST_DONE;
                        end
                    end
                end else if (expired) begin
                    state_nxt = ST_ERR;
                    pend_nxt  = ERR_TIMEOUT;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            exp_byte <= 8'd0;
            idx      <= 8'd0;
            err_pend <= ERR_NONE;
            pkt_done <= 1'b0;
            pkt_ok   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_nxt;
            exp_byte <= exp_nxt;
            idx      <= idx_nxt;
            err_pend <= pend_nxt;
            pkt_done <= (state_nxt == ST_DONE) || (state_nxt == ST_ERR);
            pkt_ok   <= (state_nxt == ST_DONE);
            busy     <= (state_nxt == ST_COLLECT);
        end
    end

    // Statistics commit at the end of the DONE/ERR cycle so a clear asserted
    // during that cycle overrides the increment.
    always_ff @(posedge clk) begin
        if (rst || clr_stats) begin
            good_cnt <= '0;
            bad_cnt  <= '0;
            err_q    <= ERR_NONE;
        end else begin
            if (state == ST_DONE && good_cnt != '1) begin
                good_cnt <= good_cnt + CNT_INC;
            end
            if (state == ST_ERR) begin
                err_q <= err_pend;
                if (bad_cnt != '1) begin
                    bad_cnt <= bad_cnt + CNT_INC;
                end
            end
        end
    end

    assign err_code = err_q;

endmodule
